elevator_call_scheduler: RTL

Collective-control scheduler for a single elevator car serving FLOORS floors.
- Latches cab calls and hall up/down calls.
- Tracks the car position from the one-hot floor sensor.
- Chooses the sweep direction and drives the motor command, floor display and door.
- Sits above the motor/door datapath and replaces ad-hoc per-floor state decoding with a direction-based (SCAN) policy and a timed door.

---
 rtl/elevator_pkg.sv | 17 +
 rtl/elevator_call_reg.sv | 41 ++++
 rtl/elevator_call_scheduler.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared constants and state encoding for the elevator call scheduler.
package elevator_pkg;

  // Motor command encodings driven on AC.
  localparam logic [1:0] AC_STOP = 2'd0;
  localparam logic [1:0] AC_UP   = 2'd1;
  localparam logic [1:0] AC_DN   = 2'd2;

  // Scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DN,
    ST_DOOR
  } state_t;

endpackage

// File: rtl/elevator_call_reg.sv
// One pending-call vector with set/clear, plus here/above/below reductions
// against a floor index.
module elevator_call_reg
  import elevator_pkg::*;
#(
  parameter int FLOORS = 4,
  parameter int FLW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] req,
  input  logic [FLOORS-1:0] clr,
  input  logic [FLW-1:0]    pos,
  output logic [FLOORS-1:0] pend,
  output logic              here,
  output logic              above,
  output logic              below
);

  // Latch requests; a clear on the same bit wins because that call is being served.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend <= '0;
    end else begin
      pend <= (pend | req) & ~clr;
    end
  end

  // Reduce pending bits relative to the probed floor.
  always_comb begin
    here  = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (FLW'(i) == pos) here  = here  | pend[i];
      if (FLW'(i) >  pos) above = above | pend[i];
      if (FLW'(i) <  pos) below = below | pend[i];
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Collective-control (SCAN) scheduler for a single elevator car: latches
// cab/hall calls, tracks position, drives motor, display and timed door.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int FLOORS      = 4,
  parameter int FLW         = $clog2(FLOORS),
  parameter int DOOR_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] cab_req,
  input  logic [FLOORS-1:0] hall_up,
  input  logic [FLOORS-1:0] hall_dn,
  input  logic [FLOORS-1:0] at_floor,
  output logic [1:0]        AC,
  output logic [FLW-1:0]    DISP,
  output logic              open,
  output logic              dir_up,
  output logic [FLOORS-1:0] cab_pend,
  output logic [FLOORS-1:0] up_pend,
  output logic [FLOORS-1:0] dn_pend
);

  localparam int CW = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CW-1:0]     CNT_LOAD = CW'(DOOR_CYCLES - 1);
  localparam logic [FLW-1:0]    ONE      = FLW'(1);
  localparam logic [FLW-1:0]    TOP      = FLW'(FLOORS - 1);
  localparam logic [FLOORS-1:0] UP_MASK  = ~(FLOORS'(1) << (FLOORS - 1));
  localparam logic [FLOORS-1:0] DN_MASK  = ~FLOORS'(1);

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [1:0]        ac_n;
  logic [FLW-1:0]    disp_n;
  logic              open_n, dir_n;

  logic [FLW-1:0]    probe;
  logic [FLOORS-1:0] p_oh;
  logic [FLOORS-1:0] up_req, dn_req;
  logic [FLOORS-1:0] clr_cab, clr_up, clr_dn;
  logic              cab_here, up_here, dn_here;
  logic              cab_above, up_above, dn_above;
  logic              cab_below, up_below, dn_below;
  logic              here, above, below;
  logic              arrive, entry, beyond, reload, nd;

  assign up_req = hall_up & UP_MASK;
  assign dn_req = hall_dn & DN_MASK;

  // While moving, reductions are taken against the floor being approached so
  // the stop decision and door-entry clears are known on the arrival cycle.
  always_comb begin
    probe = DISP;
    if (state == ST_MOVE_UP && DISP != TOP) begin
      probe = DISP + ONE;
    end else if (state == ST_MOVE_DN && DISP != '0) begin
      probe = DISP - ONE;
    end
  end

  assign p_oh   = FLOORS'(1) << probe;
  assign arrive = (probe != DISP) && at_floor[probe];

  elevator_call_reg #(.FLOORS(FLOORS), .FLW(FLW)) u_cab (
    .clk(clk), .reset(reset), .req(cab_req), .clr(clr_cab), .pos(probe),
    .pend(cab_pend), .here(cab_here), .above(cab_above), .below(cab_below)
  );

  elevator_call_reg #(.FLOORS(FLOORS), .FLW(FLW)) u_up (
    .clk(clk), .reset(reset), .req(up_req), .clr(clr_up), .pos(probe),
    .pend(up_pend), .here(up_here), .above(up_above), .below(up_below)
  );

  elevator_call_reg #(.FLOORS(FLOORS), .FLW(FLW)) u_dn (
    .clk(clk), .reset(reset), .req(dn_req), .clr(clr_dn), .pos(probe),
    .pend(dn_pend), .here(dn_here), .above(dn_above), .below(dn_below)
  );

  assign here  = cab_here  | up_here  | dn_here;
  assign above = cab_above | up_above | dn_above;
  assign below = cab_below | up_below | dn_below;

  // Next-state, next-output and call-clear decode.
  always_comb begin
    state_n = state;
    ac_n    = AC;
    disp_n  = DISP;
    open_n  = open;
    dir_n   = dir_up;
    cnt_n   = cnt;
    clr_cab = '0;
    clr_up  = '0;
    clr_dn  = '0;
    entry   = 1'b0;
    beyond  = 1'b0;
    reload  = 1'b0;
    nd      = dir_up;

    unique case (state)
      ST_IDLE: begin
        if (here) begin
          entry = 1'b1;
        end else if (above) begin
          state_n = ST_MOVE_UP;
          ac_n    = AC_UP;
          dir_n   = 1'b1;
        end else if (below) begin
          state_n = ST_MOVE_DN;
          ac_n    = AC_DN;
          dir_n   = 1'b0;
        end
      end

      ST_MOVE_UP: begin
        if (arrive) begin
          disp_n = probe;
          // no-calls-above also covers the top floor
          if (cab_here || up_here || !above) entry = 1'b1;
        end
      end

      ST_MOVE_DN: begin
        if (arrive) begin
          disp_n = probe;
          if (cab_here || dn_here || !below) entry = 1'b1;
        end
      end

      ST_DOOR: begin
        // Pending bits for these calls are already zero, so clearing them
        // every cycle only suppresses fresh presses at this floor.
        clr_cab = p_oh;
        if (dir_up) clr_up = p_oh;
        else        clr_dn = p_oh;
        reload = |(cab_req & p_oh) || (dir_up ? |(up_req & p_oh) : |(dn_req & p_oh));
        if (reload) begin
          cnt_n = CNT_LOAD;
        end else if (cnt == '0) begin
          open_n = 1'b0;
          if (dir_up ? above : below) begin
            state_n = dir_up ? ST_MOVE_UP : ST_MOVE_DN;
            ac_n    = dir_up ? AC_UP : AC_DN;
          end else if (dir_up ? below : above) begin
            dir_n   = ~dir_up;
            state_n = dir_up ? ST_MOVE_DN : ST_MOVE_UP;
            ac_n    = dir_up ? AC_DN : AC_UP;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (entry) begin
      state_n = ST_DOOR;
      ac_n    = AC_STOP;
      open_n  = 1'b1;
      cnt_n   = CNT_LOAD;
      beyond  = dir_up ? above : below;
      clr_cab = p_oh;
      if (dir_up) clr_up = p_oh;
      else        clr_dn = p_oh;
      if (!beyond) begin
        clr_up = p_oh;
        clr_dn = p_oh;
        nd     = ~dir_up;
      end
      if (probe == TOP) nd = 1'b0;
      if (probe == '0)  nd = 1'b1;
      dir_n = nd;
    end
  end

  // Register state and all outputs; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      AC     <= AC_STOP;
      DISP   <= '0;
      open   <= 1'b0;
      dir_up <= 1'b1;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      AC     <= ac_n;
      DISP   <= disp_n;
      open   <= open_n;
      dir_up <= dir_n;
      cnt    <= cnt_n;
    end
  end

endmodule
